// File: rtl/chan_delay_line.sv
// Per-channel programmable delay line with fill tracking and delayed bit-0 edge detect; CHAN_DELAY_FALLING_EN adds falling edges.
// Latency: latched delay d (1..MAX_DELAY) enabled cycles, tap mux output; no backpressure, en=0 freezes everything.
module chan_delay_line #(
  parameter int CHANNELS      = 4,
  parameter int WIDTH         = 8,
  parameter int MAX_DELAY     = 16,
  parameter int DEFAULT_DELAY = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             en,
  input  logic [CHANNELS*WIDTH-1:0]        in_data,
  input  logic [$clog2(MAX_DELAY+1)-1:0]   delay_sel,
  input  logic                             delay_load,
  output logic [CHANNELS*WIDTH-1:0]        out_data,
  output logic                             out_valid,
  output logic                             fill_done,
  output logic [CHANNELS-1:0]              rising,
  output logic [CHANNELS-1:0]              falling
);

  localparam int DW = $clog2(MAX_DELAY + 1);
  localparam int AW = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
  localparam logic [DW-1:0] RST_DELAY =
    DW'((DEFAULT_DELAY < 1) ? 1 : ((DEFAULT_DELAY > MAX_DELAY) ? MAX_DELAY : DEFAULT_DELAY));

  typedef enum logic {ST_FILL, ST_RUN} state_t;

  logic [CHANNELS*WIDTH-1:0] stage_q [MAX_DELAY];
  state_t                    state_q, state_d;
  logic [DW-1:0]             delay_q, delay_d;
  logic [DW-1:0]             cnt_q, cnt_d;
  logic                      first_q, first_d;
  logic                      prev_run_q;
  logic [CHANNELS-1:0]       prev_bit_q;
  logic [CHANNELS-1:0]       tap_bit0;
  logic [AW-1:0]             tap_idx;
  logic                      edge_ok;

  function automatic logic [DW-1:0] clamp_delay(input logic [DW-1:0] sel);
    if (sel == '0) begin
      return DW'(1);
    end else if (int'(sel) > MAX_DELAY) begin
      return DW'(MAX_DELAY);
    end
    return sel;
  endfunction

  // Stages keep their contents across delay reloads; only reset clears them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_DELAY; i++) begin
        stage_q[i] <= '0;
      end
    end else if (en) begin
      stage_q[0] <= in_data;
      for (int i = 1; i < MAX_DELAY; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign tap_idx  = AW'(delay_q - DW'(1));
  assign out_data = stage_q[tap_idx];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_FILL;
      delay_q <= RST_DELAY;
      cnt_q   <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      delay_q <= delay_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
    end
  end

  // A load restarts the fill from zero; its own shift is not counted.
  always_comb begin
    state_d = state_q;
    delay_d = delay_q;
    cnt_d   = cnt_q;
    first_d = 1'b0;
    if (delay_load) begin
      delay_d = clamp_delay(delay_sel);
      cnt_d   = '0;
      state_d = ST_FILL;
    end else if (en && (state_q == ST_FILL)) begin
      cnt_d = cnt_q + DW'(1);
      if (cnt_d >= delay_q) begin
        state_d = ST_RUN;
        first_d = 1'b1;
      end
    end
  end

  assign out_valid = (state_q == ST_RUN);
  assign fill_done = first_q && !delay_load;

  always_comb begin
    tap_bit0 = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      tap_bit0[c] = out_data[c*WIDTH];
    end
  end

  // History advances only on enabled cycles, so edges compare enabled-cycle neighbours.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_run_q <= 1'b0;
      prev_bit_q <= '0;
    end else if (en) begin
      prev_run_q <= (state_q == ST_RUN);
      prev_bit_q <= tap_bit0;
    end
  end

  assign edge_ok = (state_q == ST_RUN) && en && prev_run_q;
  assign rising  = {CHANNELS{edge_ok}} & tap_bit0 & ~prev_bit_q;

`ifdef CHAN_DELAY_FALLING_EN
  assign falling = {CHANNELS{edge_ok}} & ~tap_bit0 & prev_bit_q;
`else
  assign falling = '0;
`endif

endmodule

// File: tb/tb_chan_delay_line.sv
// Directed bench for chan_delay_line: stimulus pushes per-cycle expectations, a negedge monitor pops and compares.
module tb_chan_delay_line;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [31:0] in_data;
  logic [4:0]  delay_sel;
  logic        delay_load;
  logic [31:0] out_data;
  logic        out_valid;
  logic        fill_done;
  logic [3:0]  rising;
  logic [3:0]  falling;

  chan_delay_line #(
    .CHANNELS(4), .WIDTH(8), .MAX_DELAY(16), .DEFAULT_DELAY(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_data(in_data),
    .delay_sel(delay_sel), .delay_load(delay_load),
    .out_data(out_data), .out_valid(out_valid), .fill_done(fill_done),
    .rising(rising), .falling(falling)
  );

  typedef struct {
    bit          chk;
    bit          dchk;
    bit          valid;
    bit          fd;
    logic [3:0]  rise;
    logic [3:0]  fall;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] hist[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc_n = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] D(input int v);
    logic [31:0] t;
    logic [4:0]  s;
    t = v;
    s = t[4:0];
    return {2'd3, s, 1'b0, 2'd2, s, 1'b0, 2'd1, s, 1'b0, 2'd0, s, 1'b0};
  endfunction

  task automatic chk(input string name, input int cyc, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s cycle %0d: got %h want %h", name, cyc, got, want);
    end
  endtask

  // lag: -2 skip the cycle, -1 skip data, 0+ expected data is the input from lag enabled cycles back.
  task automatic cyc(input bit e, input logic [31:0] din, input bit ld, input logic [4:0] sel,
                     input bit rst, input bit xv, input bit xfd, input int lag,
                     input logic [3:0] xr, input logic [3:0] xfl);
    exp_t x;
    @(posedge clk);
    #1;
    en = e; in_data = din; delay_load = ld; delay_sel = sel; rst_n = !rst;
    cyc_n++;
    x.cyc   = cyc_n;
    x.chk   = (lag != -2);
    x.dchk  = (lag >= 0);
    x.valid = xv;
    x.fd    = xfd;
    x.rise  = xr;
`ifdef CHAN_DELAY_FALLING_EN
    x.fall  = xfl;
`else
    x.fall  = 4'b0;
`endif
    x.data  = (lag > 0) ? hist[hist.size() - lag] : 32'h0;
    sb.push_back(x);
    if (rst) begin
      hist.delete();
      repeat (16) hist.push_back(32'h0);
    end else if (e) begin
      hist.push_back(din);
    end
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      if (x.chk) begin
        chk("out_valid", x.cyc, {31'b0, out_valid}, {31'b0, x.valid});
        chk("fill_done", x.cyc, {31'b0, fill_done}, {31'b0, x.fd});
        chk("rising",    x.cyc, {28'b0, rising},    {28'b0, x.rise});
        chk("falling",   x.cyc, {28'b0, falling},   {28'b0, x.fall});
        if (x.dchk) chk("out_data", x.cyc, out_data, x.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ens [7]  = '{1, 0, 0, 1, 1, 1, 1};
    bit vld [7]  = '{0, 0, 0, 0, 0, 1, 1};
    bit fds [7]  = '{0, 0, 0, 0, 0, 1, 0};
    bit pat [8]  = '{0, 1, 1, 0, 0, 0, 0, 0};
    rst_n = 1'b0; en = 1'b0; in_data = '0; delay_sel = '0; delay_load = 1'b0;

    // Reset, then default delay 4 with a ramp.
    cyc(1, D(0), 0, 0, 1, 0, 0, -2, 0, 0);
    cyc(1, D(0), 0, 0, 1, 0, 0, 4, 0, 0);
    for (int k = 1; k <= 10; k++)
      cyc(1, D(k), 0, 0, 0, k >= 5, k == 5, 4, 0, 0);

    // Reload to 7 while running.
    cyc(1, D(11), 1, 7, 0, 1, 0, 4, 0, 0);
    for (int j = 1; j <= 9; j++)
      cyc(1, D(11 + j), 0, 0, 0, j >= 8, j == 8, 7, 0, 0);

    // Clamp: 0 -> 1, 31 -> 16.
    cyc(1, D(21), 1, 0, 0, 1, 0, 7, 0, 0);
    for (int j = 1; j <= 3; j++)
      cyc(1, D(21 + j), 0, 0, 0, j >= 2, j == 2, 1, 0, 0);
    cyc(1, D(25), 1, 31, 0, 1, 0, 1, 0, 0);
    for (int j = 1; j <= 18; j++)
      cyc(1, D(25 + j), 0, 0, 0, j >= 17, j == 17, 16, 0, 0);

    // Delay 3 with two frozen cycles during fill.
    cyc(1, D(44), 1, 3, 0, 1, 0, 16, 0, 0);
    for (int j = 0; j < 7; j++)
      cyc(ens[j], D(45 + j), 0, 0, 0, vld[j], fds[j], 3, 0, 0);

    // Channel 2 bit 0 pattern 0,1,1,0 seen at the tap three cycles later.
    for (int j = 0; j < 8; j++)
      cyc(1, D(52 + j) | ({31'b0, pat[j]} << 16), 0, 0, 0, 1, 0, 3,
          (j == 4) ? 4'b0100 : 4'b0000, (j == 6) ? 4'b0100 : 4'b0000);

    // Reset coincident with a load: default delay wins.
    cyc(1, D(60), 1, 7, 1, 1, 0, 3, 0, 0);
    for (int j = 1; j <= 6; j++)
      cyc(1, D(60 + j), 0, 0, 0, j >= 5, j == 5, 4, 0, 0);

    // Load on the first RUN cycle suppresses fill_done.
    cyc(1, D(67), 1, 2, 0, 1, 0, 4, 0, 0);
    cyc(1, D(68), 0, 0, 0, 0, 0, 2, 0, 0);
    cyc(1, D(69), 0, 0, 0, 0, 0, 2, 0, 0);
    cyc(1, D(70), 1, 2, 0, 1, 0, 2, 0, 0);
    cyc(1, D(71), 0, 0, 0, 0, 0, 2, 0, 0);
    cyc(1, D(72), 0, 0, 0, 0, 0, 2, 0, 0);
    cyc(1, D(73), 0, 0, 0, 1, 1, 2, 0, 0);
    cyc(1, D(74), 0, 0, 0, 1, 0, 2, 0, 0);

    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drain", cyc_n, sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/chan_delay_line.md
CHAN_DELAY_LINE -- requirements
Module: chan_delay_line

Interface
REQ-001 The module SHALL have parameter CHANNELS, default 4, number of independent data channels.
REQ-002 The module SHALL have parameter WIDTH, default 8, bits per channel.
REQ-003 The module SHALL have parameter MAX_DELAY, default 16, largest selectable delay in cycles (>=1).
REQ-004 The module SHALL have parameter DEFAULT_DELAY, default 4, delay in force after reset.
REQ-005 The module SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 The module SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-007 The module SHALL have port en  input  1  shift enable.
REQ-008 The module SHALL have port in_data  input  CHANNELS*WIDTH  packed channel inputs, channel 0 in LSBs.
REQ-009 The module SHALL have port delay_sel  input  $clog2(MAX_DELAY+1)  requested delay.
REQ-010 The module SHALL have port delay_load  input  1  one-cycle strobe latching delay_sel.
REQ-011 The module SHALL have port out_data  output  CHANNELS*WIDTH  delayed channel data.
REQ-012 The module SHALL have port out_valid  output  1  out_data holds post-fill data.
REQ-013 The module SHALL have port fill_done  output  1  one-cycle pulse on FILL->RUN.
REQ-014 The module SHALL have port rising  output  CHANNELS  per-channel rising edge of delayed bit 0.
REQ-015 The module SHALL have port falling  output  CHANNELS  per-channel falling edge of delayed bit 0.

Function
REQ-016 The delay line SHALL be MAX_DELAY stages per channel, shifting only in cycles where en=1; en=0 SHALL freeze all stages, fill counter and edge history.
REQ-017 With delay d latched, out_data SHALL equal the in_data sampled d enabled cycles earlier (tap mux, no extra register).
REQ-018 Latched delay SHALL be clamped: delay_sel=0 -> 1; delay_sel>MAX_DELAY -> MAX_DELAY.
REQ-019 The FSM SHALL have states FILL and RUN; out_valid=1 exactly when state=RUN.
REQ-020 delay_load SHALL latch the clamped delay, clear the fill counter and force FILL, regardless of state or en; the load cycle's shift, if any, SHALL not count.
REQ-021 In FILL the fill counter SHALL increment per enabled cycle; on reaching the latched delay the FSM SHALL enter RUN.
REQ-022 With en held 1, delay_load in cycle n SHALL give out_valid=1 from cycle n+1+d.
REQ-023 fill_done SHALL be 1 only in the first RUN cycle after a FILL; a delay_load in that cycle SHALL suppress it.
REQ-024 rising[c] SHALL be 1 when state=RUN, en=1, the prior enabled cycle was also RUN, and delayed bit 0 of channel c is 1 now and was 0 then.
REQ-025 No edge output SHALL assert in the first RUN cycle after FILL, nor while en=0.
REQ-026 The delay line contents SHALL NOT be flushed by delay_load.

Reset
REQ-027 On rst_n=0 at a clk edge: all stages 0, latched delay=clamped DEFAULT_DELAY, fill counter 0, state FILL, edge history cleared.
REQ-028 During and after reset until RUN: out_valid=0, fill_done=0, rising=0, falling=0; out_data shows the zeroed tap.
REQ-029 Reset asserted mid-FILL or mid-RUN SHALL take effect on that edge, overriding delay_load and en.

Configuration
REQ-030 With macro CHAN_DELAY_FALLING_EN defined, falling[c] SHALL follow REQ-024 with polarity inverted (1 now, was 1 prior -> now 0); without it falling SHALL be tied 0 and no falling-edge logic SHALL be built.

Verification
REQ-031 Reset, en=1, DEFAULT_DELAY=4, ramp input 1,2,3... -> out_valid rises in the 5th cycle after reset release, out_data lags in_data by 4, fill_done single pulse.
REQ-032 In RUN, delay_load with delay_sel=7 -> out_valid drops next cycle, returns 8 cycles after load cycle, lag now 7.
REQ-033 delay_sel=0 then delay_sel=31 (MAX_DELAY=16) -> effective lags 1 and 16.
REQ-034 en toggled 1,0,0,1 during FILL with d=3 -> out_valid delayed by exactly 2 cycles; out_data stable while en=0.
REQ-035 Channel 2 bit 0 pattern 0,1,1,0 in RUN -> rising[2] one cycle, falling[2] one cycle only with CHAN_DELAY_FALLING_EN, else always 0; other channels silent.
REQ-036 rst_n low for one cycle mid-RUN coincident with delay_load -> outputs per REQ-028, latched delay=DEFAULT_DELAY.
